// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin scheduler feeding a UART transmitter.
// Frames are 8N1 by default. Define UART_TX_PARITY_EN to add one even-parity
// bit between the data bits and the stop bit.
module uart_tx_sched #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic       last_grant
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      idx_reg;
  logic [7:0]      shift_reg;
  logic            tx_reg;
  logic            last_grant_reg;
`ifdef UART_TX_PARITY_EN
  logic            par_reg;
`endif

  logic idle_open;
  logic bit_done;

  // Grant decision: only in IDLE (and not while reset is held); on a tie the
  // requester that was not served last wins, so neither can be starved.
  always_comb begin
    idle_open  = (state_reg == S_IDLE) && !rst;
    req0_ready = idle_open && req0_valid && (!req1_valid || last_grant_reg);
    req1_ready = idle_open && req1_valid && (!req0_valid || !last_grant_reg);
    bit_done   = (cnt_reg == CNT_MAX);
  end

  assign uart_tx    = tx_reg;
  assign busy       = (state_reg != S_IDLE);
  assign last_grant = last_grant_reg;

  // Frame sequencer: accepts a byte in IDLE, then walks START/DATA/(PARITY)/STOP,
  // each bit lasting CLK_DIV cycles; the line value is registered one edge ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      tx_reg         <= 1'b1;
      last_grant_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_reg        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          cnt_reg <= '0;
          idx_reg <= '0;
          if (req0_ready) begin
            shift_reg      <= req0_data;
            last_grant_reg <= 1'b0;
            tx_reg         <= 1'b0;
            state_reg      <= S_START;
`ifdef UART_TX_PARITY_EN
            par_reg        <= ^req0_data;
`endif
          end else if (req1_ready) begin
            shift_reg      <= req1_data;
            last_grant_reg <= 1'b1;
            tx_reg         <= 1'b0;
            state_reg      <= S_START;
`ifdef UART_TX_PARITY_EN
            par_reg        <= ^req1_data;
`endif
          end
        end
        S_START: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            tx_reg    <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            state_reg <= S_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt_reg <= '0;
            if (idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_reg    <= par_reg;
              state_reg <= S_PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= S_STOP;
`endif
            end else begin
              idx_reg   <= idx_reg + 3'd1;
              tx_reg    <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            tx_reg    <= 1'b1;
            state_reg <= S_STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          tx_reg    <= 1'b1;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: a queue-based line model predicts every cycle of
// the serial line, busy, ready and last_grant; directed scenarios pin the model
// with literal expectations, then randomized traffic with random resets runs.
module tb_uart_tx_sched;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN = FRAME_BITS * CLK_DIV;
  localparam int SPACING   = FRAME_LEN + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data  = 8'h00;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data  = 8'h00;
  logic       req0_ready, req1_ready, uart_tx, busy, last_grant;

  always #5 clk = ~clk;

  uart_tx_sched #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .last_grant (last_grant)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         line_q[$];      // predicted line value for each upcoming cycle of a frame
  bit         m_last = 1'b1;
  bit         acc0, acc1;
  int         cyc = 0;
  int         hs_cyc[$];
  bit         hs_who[$];
  logic [7:0] hs_data[$];

  always @(posedge clk) begin
    logic [7:0] d;
    cyc++;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      line_q.delete();
      m_last = 1'b1;
    end else if (line_q.size() != 0) begin
      void'(line_q.pop_front());
    end else begin
      if (req0_valid && req1_valid) begin
        if (m_last) acc0 = 1'b1; else acc1 = 1'b1;
      end else if (req0_valid) begin
        acc0 = 1'b1;
      end else if (req1_valid) begin
        acc1 = 1'b1;
      end
      if (acc0 || acc1) begin
        d = acc0 ? req0_data : req1_data;
        m_last = acc1;
        hs_cyc.push_back(cyc);
        hs_who.push_back(acc1);
        hs_data.push_back(d);
        for (int i = 0; i < CLK_DIV; i++) line_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int i = 0; i < CLK_DIV; i++) line_q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < CLK_DIV; i++) line_q.push_back(^d);
`endif
        for (int i = 0; i < CLK_DIV; i++) line_q.push_back(1'b1);
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    bit e_tx, e_busy, e_last, e_r0, e_r1, idle;
    if (rst) begin
      e_tx = 1'b1; e_busy = 1'b0; e_last = 1'b1; e_r0 = 1'b0; e_r1 = 1'b0;
    end else begin
      idle   = (line_q.size() == 0);
      e_tx   = idle ? 1'b1 : line_q[0];
      e_busy = !idle;
      e_last = m_last;
      e_r0   = idle && req0_valid && (!req1_valid || m_last);
      e_r1   = idle && req1_valid && (!req0_valid || !m_last);
    end
    check("cyc_uart_tx", uart_tx, e_tx);
    check("cyc_busy", busy, e_busy);
    check("cyc_last_grant", last_grant, e_last);
    check("cyc_req0_ready", req0_ready, e_r0);
    check("cyc_req1_ready", req1_ready, e_r1);
  end

  // ---------------- requester drivers ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always @(posedge clk) begin
    #1;
    if (acc0 && q0.size() != 0) void'(q0.pop_front());
    if (acc1 && q1.size() != 0) void'(q1.pop_front());
    req0_valid = (q0.size() != 0);
    req0_data  = req0_valid ? q0[0] : 8'($urandom);
    req1_valid = (q1.size() != 0);
    req1_data  = req1_valid ? q1[0] : 8'($urandom);
  end

  // Returns at the first negedge after the n-th handshake (frame cycle 1).
  task automatic wait_hs(input int n);
    int t;
    t = 0;
    while (hs_cyc.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (hs_cyc.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_hs: got %0d handshakes expected %0d", hs_cyc.size(), n);
    end
  endtask

  task automatic wait_quiet();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || line_q.size() != 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", (t < 5000), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int base;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_last_grant", last_grant, 1);
    #1 rst = 1'b0;

    // Single byte 0x55 from requester 0, frame timeline pinned by literals.
    @(negedge clk);
    q0.push_back(8'h55);
    base = hs_cyc.size();
    wait_hs(base + 1);
    for (int k = 1; k <= FRAME_LEN + 1; k++) begin
      if (k == 1)  begin check("b55_k1_tx", uart_tx, 0); check("b55_k1_busy", busy, 1); check("b55_k1_rdy0", req0_ready, 0); end
      if (k == 4)  check("b55_k4_tx", uart_tx, 0);
      if (k == 5)  check("b55_bit0", uart_tx, 1);
      if (k == 9)  check("b55_bit1", uart_tx, 0);
      if (k == 33) check("b55_bit7", uart_tx, 0);
`ifdef UART_TX_PARITY_EN
      if (k == 37) check("b55_parity", uart_tx, 0);
`else
      if (k == 37) check("b55_stop", uart_tx, 1);
`endif
      if (k == FRAME_LEN)     begin check("b55_last_tx", uart_tx, 1); check("b55_last_busy", busy, 1); end
      if (k == FRAME_LEN + 1) begin check("b55_idle_busy", busy, 0); check("b55_grant", last_grant, 0); end
      @(negedge clk);
    end

    // Tie after reset, then continuous contention for four frames.
    pulse_reset();
    @(negedge clk);
    q0.push_back(8'hA5); q0.push_back(8'h11);
    q1.push_back(8'h3C); q1.push_back(8'h44);
    base = hs_cyc.size();
    wait_hs(base + 4);
    if (hs_cyc.size() >= base + 4) begin
      check("tie_first_who", hs_who[base], 0);
      check("tie_first_data", hs_data[base], 8'hA5);
      check("tie_second_who", hs_who[base + 1], 1);
      check("tie_second_data", hs_data[base + 1], 8'h3C);
      check("tie_third_who", hs_who[base + 2], 0);
      check("tie_fourth_who", hs_who[base + 3], 1);
      check("tie_spacing", hs_cyc[base + 1] - hs_cyc[base], SPACING);
    end
    wait_quiet();

    // Requester 1 streaming three bytes back to back.
    q1.push_back(8'h01); q1.push_back(8'h80); q1.push_back(8'hFF);
    base = hs_cyc.size();
    wait_hs(base + 3);
    if (hs_cyc.size() >= base + 3) begin
      check("stream_sp1", hs_cyc[base + 1] - hs_cyc[base], SPACING);
      check("stream_sp2", hs_cyc[base + 2] - hs_cyc[base + 1], SPACING);
      check("stream_who", {hs_who[base], hs_who[base + 1], hs_who[base + 2]}, 3'b111);
    end
    wait_quiet();

    // Reset mid-frame during data bit 3: line and busy must clear at once.
    q0.push_back(8'hC3);
    base = hs_cyc.size();
    wait_hs(base + 1);
    repeat (17) @(negedge clk);   // now at frame cycle 18, inside data bit 3
    #1 rst = 1'b1;
    #1;
    check("midrst_tx", uart_tx, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    q0.push_back(8'h96);
    base = hs_cyc.size();
    wait_hs(base + 1);
    if (hs_cyc.size() >= base + 1) check("midrst_next_data", hs_data[base], 8'h96);
    wait_quiet();

`ifdef UART_TX_PARITY_EN
    // Parity bit values for 0x07 (odd weight) and 0x03 (even weight).
    q0.push_back(8'h07);
    base = hs_cyc.size();
    wait_hs(base + 1);
    repeat (36) @(negedge clk);
    check("par07_bit", uart_tx, 1);
    repeat (4) @(negedge clk);
    check("par07_stop", uart_tx, 1);
    wait_quiet();
    q0.push_back(8'h03);
    base = hs_cyc.size();
    wait_hs(base + 1);
    repeat (36) @(negedge clk);
    check("par03_bit", uart_tx, 0);
    wait_quiet();
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(8'($urandom));
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(8'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        #($urandom_range(1, 4)) rst = 1'b1;
        #1;
        check("rnd_rst_tx", uart_tx, 1);
        check("rnd_rst_busy", busy, 0);
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    wait_quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
